// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM burst arbiter: port indices and FSM states.
package sdram_arb_pkg;
  localparam int NUM_PORTS = 4;

  localparam logic [1:0] P_WR1 = 2'd0;
  localparam logic [1:0] P_WR2 = 2'd1;
  localparam logic [1:0] P_RD1 = 2'd2;
  localparam logic [1:0] P_RD2 = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARB,
    S_ISSUE,
    S_WAIT
  } arb_state_t;
endpackage

// File: rtl/sdram_port_addr.sv
// Per-port wrapping burst address counter with load/rewind handling.
module sdram_port_addr #(
  parameter int ADDR_W = 21,
  parameter int BURST  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] max_addr,
  input  logic              load,
  input  logic              step,
  input  logic              active,
  output logic [ADDR_W-1:0] addr
);
  logic [ADDR_W:0] sum;
  logic            pending;

  // One extra bit so a sum past the top of the address space still compares correctly.
  assign sum = {1'b0, addr} + (ADDR_W+1)'(BURST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr    <= base_addr;
      pending <= 1'b0;
    end else if (step) begin
      pending <= 1'b0;
      if (pending || load)
        addr <= base_addr;
      else if (sum >= {1'b0, max_addr})
        addr <= base_addr;
      else
        addr <= sum[ADDR_W-1:0];
    end else if (load) begin
      // A burst in flight keeps its address; the rewind lands when it completes.
      if (active)
        pending <= 1'b1;
      else
        addr <= base_addr;
    end
  end
endmodule

// File: rtl/sdram_burst_arbiter.sv
// Round-robin burst scheduler between four frame-buffer FIFO ports and the SDRAM engine.
// Optional macro RD_URGENT_EN: read ports below RD_LOW_WM pre-empt round-robin.
module sdram_burst_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W     = 21,
  parameter int LVL_W      = 10,
  parameter int FIFO_DEPTH = 512,
  parameter int BURST      = 256,
  parameter int RD_LOW_WM  = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            port_en,
  input  logic [4*LVL_W-1:0]    level,
  input  logic [4*ADDR_W-1:0]   base_addr,
  input  logic [4*ADDR_W-1:0]   max_addr,
  input  logic [3:0]            load,
  input  logic                  refresh_req,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [1:0]            cmd_port,
  output logic                  cmd_write,
  output logic [ADDR_W-1:0]     cmd_addr,
  output logic [LVL_W-1:0]      cmd_len,
  input  logic                  cmd_done,
  output logic                  busy
);
  localparam logic [LVL_W-1:0] BURST_L = LVL_W'(BURST);
  localparam logic [LVL_W-1:0] RD_MAX  = LVL_W'(FIFO_DEPTH - BURST);

  arb_state_t           state;
  logic [1:0]           rr_ptr;
  logic [1:0]           sel;
  logic [1:0]           idx;
  logic                 found;
  logic [NUM_PORTS-1:0] elig;
  logic [ADDR_W-1:0]    addr [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    logic [LVL_W-1:0] lvl;
    logic             step;
    logic             active;

    assign lvl = level[g*LVL_W +: LVL_W];
    if (g < 2) begin : g_wr
      assign elig[g] = port_en[g] && (lvl >= BURST_L);
    end else begin : g_rd
      assign elig[g] = port_en[g] && (lvl <= RD_MAX);
    end

    assign active = ((state == S_ISSUE) || (state == S_WAIT)) && (cmd_port == 2'(g));
    assign step   = cmd_done && (state == S_WAIT) && (cmd_port == 2'(g));

    sdram_port_addr #(
      .ADDR_W (ADDR_W),
      .BURST  (BURST)
    ) u_addr (
      .clk       (clk),
      .rst_n     (rst_n),
      .base_addr (base_addr[g*ADDR_W +: ADDR_W]),
      .max_addr  (max_addr[g*ADDR_W +: ADDR_W]),
      .load      (load[g]),
      .step      (step),
      .active    (active),
      .addr      (addr[g])
    );
  end

`ifdef RD_URGENT_EN
  localparam logic [LVL_W-1:0] WM_L = LVL_W'(RD_LOW_WM);
  logic [LVL_W-1:0] lvl_rd1;
  logic [LVL_W-1:0] lvl_rd2;
  assign lvl_rd1 = level[2*LVL_W +: LVL_W];
  assign lvl_rd2 = level[3*LVL_W +: LVL_W];
`endif

  always_comb begin
    sel   = rr_ptr;
    idx   = rr_ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = rr_ptr + 2'(k);
      if (!found && elig[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
`ifdef RD_URGENT_EN
    if (elig[P_RD1] && (lvl_rd1 < WM_L))
      sel = P_RD1;
    else if (elig[P_RD2] && (lvl_rd2 < WM_L))
      sel = P_RD2;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cmd_valid <= 1'b0;
      cmd_port  <= 2'd0;
      cmd_write <= 1'b0;
      cmd_addr  <= '0;
      cmd_len   <= '0;
      busy      <= 1'b0;
      rr_ptr    <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if ((|elig) && !refresh_req) begin
            state <= S_ARB;
            busy  <= 1'b1;
          end
        end
        S_ARB: begin
          // Eligibility may have dropped since IDLE; abandon without issuing.
          if (|elig) begin
            cmd_port  <= sel;
            cmd_write <= (sel == P_WR1) || (sel == P_WR2);
            cmd_addr  <= addr[sel];
            cmd_len   <= BURST_L;
            state     <= S_ISSUE;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (!cmd_valid) begin
            cmd_valid <= 1'b1;
          end else if (cmd_ready) begin
            cmd_valid <= 1'b0;
            rr_ptr    <= cmd_port + 2'd1;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cmd_done) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Directed self-checking bench for sdram_burst_arbiter (default or RD_URGENT_EN build).
module tb_sdram_burst_arbiter;
  localparam int ADDR_W = 21;
  localparam int LVL_W  = 10;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [3:0]          port_en;
  logic [4*LVL_W-1:0]  level;
  logic [4*ADDR_W-1:0] base_addr;
  logic [4*ADDR_W-1:0] max_addr;
  logic [3:0]          load;
  logic                refresh_req;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_port;
  logic                cmd_write;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [LVL_W-1:0]    cmd_len;
  logic                cmd_done;
  logic                busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sdram_burst_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .port_en     (port_en),
    .level       (level),
    .base_addr   (base_addr),
    .max_addr    (max_addr),
    .load        (load),
    .refresh_req (refresh_req),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_port    (cmd_port),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .cmd_done    (cmd_done),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_level(input int i, input int v);
    level[i*LVL_W +: LVL_W] = LVL_W'(v);
  endtask

  task automatic set_base(input int i, input int v);
    base_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(v);
  endtask

  task automatic set_max(input int i, input int v);
    max_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(v);
  endtask

  // Returns the number of falling edges until cmd_valid is seen.
  task automatic wait_valid(input string tag, output int cyc);
    cyc = 0;
    while (cmd_valid !== 1'b1 && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_seen"}, 32'(cmd_valid === 1'b1), 32'd1);
  endtask

  task automatic burst(input string tag, input logic [1:0] p, input int a);
    int cyc;
    wait_valid(tag, cyc);
    check({tag, "_port"},  32'(cmd_port), 32'(p));
    check({tag, "_write"}, 32'(cmd_write), 32'(!p[1]));
    check({tag, "_addr"},  32'(cmd_addr), a);
    @(negedge clk);
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
  endtask

  initial begin
    int  lat;
    logic seen;
    rst_n       = 1'b0;
    port_en     = 4'b0000;
    level       = '0;
    load        = 4'b0000;
    refresh_req = 1'b0;
    cmd_ready   = 1'b1;
    cmd_done    = 1'b0;
    set_base(0, 0);      set_max(0, 480000);
    set_base(1, 0);      set_max(1, 480000);
    set_base(2, 100000); set_max(2, 200000);
    set_base(3, 300000); set_max(3, 400000);
    repeat (3) @(negedge clk);

    check("rst_valid", 32'(cmd_valid), 0);
    check("rst_port",  32'(cmd_port), 0);
    check("rst_write", 32'(cmd_write), 0);
    check("rst_addr",  32'(cmd_addr), 0);
    check("rst_len",   32'(cmd_len), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_addr2", 32'(dut.addr[2]), 100000);

    // Single WR1 burst: latency, fields, increment.
    port_en = 4'b0001;
    set_level(0, 300);
    rst_n = 1'b1;
    wait_valid("t1", lat);
    check("t1_latency", 32'(lat), 3);
    check("t1_port",  32'(cmd_port), 0);
    check("t1_write", 32'(cmd_write), 1);
    check("t1_addr",  32'(cmd_addr), 0);
    check("t1_len",   32'(cmd_len), 256);
    @(negedge clk);
    check("t1_valid_drop", 32'(cmd_valid), 0);
    check("t1_busy_wait",  32'(busy), 1);
    cmd_done = 1'b1;
    port_en  = 4'b0000;
    @(negedge clk);
    cmd_done = 1'b0;
    check("t1_addr_inc", 32'(dut.addr[0]), 256);
    check("t1_busy_end", 32'(busy), 0);

    // Reset while a burst is in WAIT.
    port_en = 4'b0001;
    wait_valid("mid", lat);
    check("mid_addr", 32'(cmd_addr), 256);
    @(negedge clk);
    port_en = 4'b0000;
    rst_n   = 1'b0;
    @(negedge clk);
    check("mid_busy",  32'(busy), 0);
    check("mid_valid", 32'(cmd_valid), 0);
    check("mid_caddr", 32'(cmd_addr), 0);
    check("mid_addr0", 32'(dut.addr[0]), 0);
    rst_n = 1'b1;

    // Round-robin alternation WR1 / RD1 from rr_ptr = 0.
    port_en = 4'b0101;
    set_level(2, 0);
    burst("rr1", 2'd0, 0);
    burst("rr2", 2'd2, 100000);
    burst("rr3", 2'd0, 256);
    port_en = 4'b0000;

    // Wrap: place WR1 at 479744 via load, then restore base 0.
    set_base(0, 479744);
    load = 4'b0001;
    @(negedge clk);
    load = 4'b0000;
    set_base(0, 0);
    check("wrap_preset", 32'(dut.addr[0]), 479744);
    port_en = 4'b0001;
    burst("wrapA", 2'd0, 479744);
    wait_valid("wrapB", lat);
    check("wrap_addr", 32'(cmd_addr), 0);
    @(negedge clk);
    load = 4'b0001;
    @(negedge clk);
    load = 4'b0000;
    check("pend_hold", 32'(dut.addr[0]), 0);
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
    check("pend_rewind", 32'(dut.addr[0]), 0);
    wait_valid("ldd", lat);
    check("ldd_addr", 32'(cmd_addr), 0);
    @(negedge clk);
    load     = 4'b0001;
    cmd_done = 1'b1;
    @(negedge clk);
    load     = 4'b0000;
    cmd_done = 1'b0;
    port_en  = 4'b0000;
    check("ldd_rewind", 32'(dut.addr[0]), 0);

    // Load on an idle read port.
    set_base(2, 150000);
    load = 4'b0100;
    @(negedge clk);
    load = 4'b0000;
    check("load_idle", 32'(dut.addr[2]), 150000);

    // Refresh blocks the start of arbitration.
    refresh_req = 1'b1;
    port_en     = 4'b0001;
    seen        = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (cmd_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    check("refresh_block", 32'(seen), 0);
    refresh_req = 1'b0;
    wait_valid("rfr", lat);
    check("rfr_latency", 32'(lat), 3);
    @(negedge clk);
    cmd_done = 1'b1;
    port_en  = 4'b0000;
    @(negedge clk);
    cmd_done = 1'b0;

    // Urgent read vs round-robin from rr_ptr = 0.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    port_en = 4'b1001;
    set_level(0, 300);
    set_level(3, 100);
    wait_valid("urg", lat);
`ifdef RD_URGENT_EN
    check("urg_port", 32'(cmd_port), 3);
`else
    check("urg_port", 32'(cmd_port), 0);
`endif
    @(negedge clk);
    cmd_done = 1'b1;
    port_en  = 4'b0000;
    @(negedge clk);
    cmd_done = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sdram_burst_arbiter.md
# sdram_burst_arbiter

Schedules SDRAM burst transfers between the four frame-buffer FIFO ports: camera write (WR1), spare write (WR2), VGA read (RD1) and spare read (RD2). Each cycle it checks FIFO fill levels, grants one port a fixed-length burst, and hands a single command to the SDRAM command engine. It keeps one wrapping address counter per port. It runs in the CTRL_CLK (100 MHz) domain, between the port FIFOs and the SDRAM command/refresh engine.

## Interface
- ADDR_W, 21, SDRAM word address width
- LVL_W, 10, FIFO level width
- FIFO_DEPTH, 512, words per port FIFO
- BURST, 256, words per granted burst; must be ≤ FIFO_DEPTH
- RD_LOW_WM, 128, urgent threshold for read ports (used only with RD_URGENT_EN)
- clk  in  1  CTRL_CLK
- rst_n  in  1  reset, synchronous, active-low
- port_en  in  4  per-port enable; bits [0]=WR1, [1]=WR2, [2]=RD1, [3]=RD2
- level  in  4*LVL_W  per-port FIFO occupancy, already synchronised into clk; slice i = port i
- base_addr  in  4*ADDR_W  per-port start address
- max_addr  in  4*ADDR_W  per-port end address (exclusive)
- load  in  4  per-port one-cycle pulse that rewinds the port address to base
- refresh_req  in  1  refresh pending in the command engine
- cmd_valid  out  1  command offered
- cmd_ready  in  1  engine accepts the command
- cmd_port  out  2  granted port index
- cmd_write  out  1  1 = write burst (ports 0/1), 0 = read burst (ports 2/3)
- cmd_addr  out  ADDR_W  burst start address
- cmd_len  out  LVL_W  burst length; always BURST
- cmd_done  in  1  one-cycle pulse when the burst completes
- busy  out  1  a burst is granted and not yet done

## Operation
- Eligibility:
  - write port i is eligible if port_en[i] && level_i ≥ BURST;
  - read port i is eligible if port_en[i] && level_i ≤ FIFO_DEPTH−BURST.
- FSM states: IDLE, ARB, ISSUE, WAIT.
  - IDLE → ARB when any port is eligible and refresh_req = 0.
  - ARB: selects the winner by round-robin, starting at rr_ptr. It registers cmd_port, cmd_write, cmd_addr = addr[winner] and cmd_len. → ISSUE.
  - ISSUE: cmd_valid = 1. The command fields stay stable until cmd_ready. On cmd_valid && cmd_ready → WAIT, and rr_ptr ← winner+1 (mod 4).
  - WAIT: on cmd_done → IDLE, and addr[winner] ← addr+BURST. If the result is ≥ max_addr, it wraps to base_addr.
- Eligibility is re-evaluated in ARB. If no port is eligible there, the FSM returns to IDLE with no command issued.
- refresh_req only blocks IDLE→ARB. A command already in ISSUE or WAIT is not withdrawn.
- load[i]:
  - If port i is not the winner in ISSUE or WAIT, addr[i] ← base_addr[i] immediately.
  - Otherwise a pending flag is set, and addr[i] ← base on cmd_done. The pending rewind takes precedence over the increment.
  - A load in the same cycle as cmd_done for that port also results in a rewind.
- Address arithmetic is ADDR_W+1 bits wide to detect overflow before the compare. Address counters are unsigned.

## Timing
- Reset values: cmd_valid 0, cmd_port 0, cmd_write 0, cmd_addr 0, cmd_len 0, busy 0, rr_ptr 0, FSM IDLE.
- During reset, addr[i] ← base_addr[i] and pending flags are cleared.
- Latency: an eligible port seen in IDLE at edge n gives cmd_valid high after edge n+2.
- After cmd_done at edge m, the FSM is in IDLE after edge m; the earliest next cmd_valid is after edge m+3.
- busy is high in ARB, ISSUE and WAIT.
- cmd_done outside WAIT is ignored.
- When rst_n is asserted mid-burst, all outputs return to reset values on that edge. The engine is reset by the same rst_n.

## Configuration
- RD_URGENT_EN defined: in ARB, any eligible read port with level_i < RD_LOW_WM wins over round-robin. RD1 takes precedence over RD2. rr_ptr still updates to winner+1.
- RD_URGENT_EN undefined: pure round-robin, and RD_LOW_WM is unused.

## Structure
- Package sdram_arb_pkg:
  - port index constants: P_WR1=0, P_WR2=1, P_RD1=2, P_RD2=3;
  - FSM state enum;
  - NUM_PORTS=4.
- Sub-module sdram_port_addr: one per port, instantiated 4×. It holds the address counter, wrap logic, load and pending-rewind handling, with inputs step (cmd_done && winner) and load.
- The top level holds the eligibility logic, the round-robin/urgent selector and the FSM.

## Test plan
- WR1 level=300, all other ports disabled, cmd_ready tied 1 → cmd_valid 2 cycles later with port 0, write 1, addr 0, len 256; after cmd_done, addr[0]=256.
- WR1 level=300 and RD1 level=0, both enabled, rr_ptr=0 → grants in order WR1, RD1, WR1 (round-robin alternation).
- base=0, max=480000, addr at 479744; cmd_done → next cmd_addr is 0 (wrap).
- load[0] pulsed while WR1 is in WAIT → cmd_done rewinds addr[0] to base with no increment; load[2] while idle → addr[2]=base on the next cycle.
- refresh_req=1 with WR1 eligible → no cmd_valid; refresh_req drops → cmd_valid 2 cycles later.
- RD_URGENT_EN, rr_ptr=0, WR1 eligible, RD2 level=100 → RD2 granted first; same stimulus without the macro → WR1 granted first.
